// File: rtl/parallax_starfield.sv
// Multi-layer parallax starfield: LFSR-seeded star table, per-layer vertical scroll
// once per frame, and a one-cycle registered pixel lookup for the compositor.
module parallax_starfield #(
  parameter int unsigned NUM_LAYERS      = 3,
  parameter int unsigned STARS_PER_LAYER = 8,
  parameter int unsigned HRES            = 640,
  parameter int unsigned VRES            = 480,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter bit          TWINKLE         = 1'b0
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               fsync,
  input  logic signed [11:0] hpos,
  input  logic signed [11:0] vpos,
  input  logic [1:0]         game_state,
  output logic [7:0]         pixel [0:2],
  output logic               active,
  output logic               ready
);

  localparam int unsigned N  = NUM_LAYERS * STARS_PER_LAYER;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = (STARS_PER_LAYER > 1) ? $clog2(STARS_PER_LAYER) : 1;
  localparam int unsigned LW = 2;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [1:0]  GS_GAMEOVER = 2'b11;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_RUN    = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [IW-1:0]   idx, idx_next;
  logic [LW-1:0]   lyr;
  logic [SW-1:0]   sub;
  logic [15:0]     lfsr, lfsr_next;
  logic [7:0]      frame_cnt;
  logic            lfsr_adv, frame_inc, step;
  logic [9:0]      draw_x;
  logic [8:0]      draw_y;
  logic [9:0]      y_sum;
  logic [8:0]      y_wrapped;
  logic            wrap;
  logic            hit;
  logic [7:0]      bright;

  logic [9:0]      star_x [N];
  logic [8:0]      star_y [N];

  function automatic logic [7:0] layer_bright(input int unsigned k);
    int unsigned b;
    b = 32'h60 + k * 32'h50;
    return (b > 32'hFF) ? 8'hFF : 8'(b);
  endfunction

  // Random draw from the current LFSR value, folded into the visible area
  always_comb begin
    draw_x = lfsr[9:0];
    if ({1'b0, lfsr[9:0]} >= 11'(HRES))
      draw_x = 10'({1'b0, lfsr[9:0]} - 11'(HRES));
    draw_y = lfsr[15:7];
    if ({1'b0, lfsr[15:7]} >= 10'(VRES))
      draw_y = 9'({1'b0, lfsr[15:7]} - 10'(VRES));
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
  end

  // Scroll step for the star currently addressed by idx
  always_comb begin
    y_sum     = {1'b0, star_y[idx]} + 10'(lyr) + 10'd1;
    wrap      = (y_sum >= 10'(VRES));
    y_wrapped = 9'(y_sum - 10'(VRES));
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state <= S_INIT;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    lfsr_adv   = 1'b0;
    frame_inc  = 1'b0;
    step       = 1'b0;
    case (state)
      S_INIT: begin
        lfsr_adv = 1'b1;
        step     = 1'b1;
        if (idx == IW'(N - 1)) begin
          state_next = S_RUN;
          idx_next   = '0;
        end else begin
          idx_next = idx + IW'(1);
        end
      end
      S_RUN: begin
        if (fsync) begin
          frame_inc = 1'b1;
          if (game_state != GS_GAMEOVER) begin
            state_next = S_UPDATE;
            idx_next   = '0;
          end
        end
      end
      S_UPDATE: begin
        lfsr_adv = wrap;
        step     = 1'b1;
        if (idx == IW'(N - 1)) begin
          state_next = S_RUN;
          idx_next   = '0;
        end else begin
          idx_next = idx + IW'(1);
        end
      end
      default: state_next = S_INIT;
    endcase
  end

  // Layer/sub-index tracker walking alongside idx
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      lyr <= '0;
      sub <= '0;
    end else if (step) begin
      if (sub == SW'(STARS_PER_LAYER - 1)) begin
        sub <= '0;
        lyr <= (lyr == LW'(NUM_LAYERS - 1)) ? '0 : lyr + LW'(1);
      end else begin
        sub <= sub + SW'(1);
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      lfsr      <= LFSR_SEED;
      frame_cnt <= '0;
      ready     <= 1'b0;
    end else begin
      if (lfsr_adv)  lfsr      <= lfsr_next;
      if (frame_inc) frame_cnt <= frame_cnt + 8'd1;
      ready <= (state != S_INIT);
    end
  end

  // Star table; INIT rewrites every entry so no reset is needed here
  always_ff @(posedge pixel_clk) begin
    if (state == S_INIT) begin
      star_x[idx] <= draw_x;
      star_y[idx] <= draw_y;
    end else if (state == S_UPDATE) begin
      star_y[idx] <= wrap ? y_wrapped : y_sum[8:0];
      if (wrap) star_x[idx] <= draw_x;
    end
  end

  // Ascending scan so that the highest matching layer wins
  always_comb begin
    hit    = 1'b0;
    bright = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (ready && ($unsigned(hpos) == {2'b00, star_x[j]}) &&
          ($unsigned(vpos) == {3'b000, star_y[j]})) begin
        hit    = 1'b1;
        bright = layer_bright(j / STARS_PER_LAYER);
        if (TWINKLE && (j < STARS_PER_LAYER) && (frame_cnt[3] == j[0]))
          bright = {1'b0, bright[7:1]};
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      active <= 1'b0;
      for (int c = 0; c < 3; c++) pixel[c] <= '0;
    end else begin
      active <= hit;
      for (int c = 0; c < 3; c++) pixel[c] <= bright;
    end
  end

endmodule

// File: tb/tb_parallax_starfield.sv
// Directed bench for parallax_starfield: plain and twinkle instances share stimulus
// and are compared against hand values and a small star-table model.
module tb_parallax_starfield;

  localparam int NS  = 24;
  localparam int SPL = 8;

  logic              pixel_clk = 1'b0;
  logic              rst;
  logic              fsync;
  logic signed [11:0] hpos, vpos;
  logic [1:0]        game_state;
  logic [7:0]        pix0 [0:2];
  logic [7:0]        pix1 [0:2];
  logic              act0, act1, rdy0, rdy1;

  always #5 pixel_clk = ~pixel_clk;

  parallax_starfield #(.TWINKLE(1'b0)) dut0 (
    .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .hpos(hpos), .vpos(vpos),
    .game_state(game_state), .pixel(pix0), .active(act0), .ready(rdy0)
  );

  parallax_starfield #(.TWINKLE(1'b1)) dut1 (
    .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .hpos(hpos), .vpos(vpos),
    .game_state(game_state), .pixel(pix1), .active(act1), .ready(rdy1)
  );

  int          n_tests;
  int          n_fail;
  logic [15:0] m_lfsr;
  int          m_x [NS];
  int          m_y [NS];
  int          m_frame;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_draw(output int x, output int y);
    x = int'(m_lfsr[9:0]);
    if (x >= 640) x -= 640;
    y = int'(m_lfsr[15:7]);
    if (y >= 480) y -= 480;
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  endtask

  task automatic m_init();
    int x, y;
    m_lfsr  = 16'hACE1;
    m_frame = 0;
    for (int j = 0; j < NS; j++) begin
      m_draw(x, y);
      m_x[j] = x;
      m_y[j] = y;
    end
  endtask

  task automatic m_update();
    int yp, x, y;
    for (int j = 0; j < NS; j++) begin
      yp = m_y[j] + j / SPL + 1;
      if (yp >= 480) begin
        m_y[j] = yp - 480;
        m_draw(x, y);
        m_x[j] = x;
      end else begin
        m_y[j] = yp;
      end
    end
  endtask

  function automatic int exp_pix(input int h, input int v, input bit twk);
    int b, k;
    b = 0;
    for (int j = 0; j < NS; j++) begin
      if (m_x[j] == h && m_y[j] == v) begin
        k = j / SPL;
        b = (k == 0) ? 'h60 : (k == 1) ? 'hB0 : 'hFF;
        if (twk && k == 0 && ((m_frame >> 3) & 1) == (j & 1)) b = b / 2;
      end
    end
    return b;
  endfunction

  function automatic int rgb(input int b);
    return (b << 16) | (b << 8) | b;
  endfunction

  task automatic probe(input int h, input int v);
    @(negedge pixel_clk);
    hpos = 12'(h);
    vpos = 12'(v);
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic probe_model(input string tag, input int h, input int v);
    int e0, e1;
    probe(h, v);
    e0 = exp_pix(h, v, 1'b0);
    e1 = exp_pix(h, v, 1'b1);
    check({tag, "_act0"}, int'(act0), int'(e0 != 0));
    check({tag, "_pix0"}, int'({pix0[0], pix0[1], pix0[2]}), rgb(e0));
    check({tag, "_act1"}, int'(act1), int'(e1 != 0));
    check({tag, "_pix1"}, int'({pix1[0], pix1[1], pix1[2]}), rgb(e1));
  endtask

  task automatic run_frame(input logic [1:0] gs);
    @(negedge pixel_clk);
    fsync      = 1'b1;
    game_state = gs;
    @(negedge pixel_clk);
    fsync   = 1'b0;
    m_frame = (m_frame + 1) % 256;
    if (gs != 2'b11) m_update();
    repeat (30) @(negedge pixel_clk);
  endtask

  // Reset, then watch ready rise exactly on the 25th cycle after release
  task automatic do_reset();
    @(negedge pixel_clk);
    rst   = 1'b1;
    fsync = 1'b0;
    @(posedge pixel_clk);
    #1;
    check("rst_ready", int'(rdy0), 0);
    check("rst_active", int'(act0), 0);
    check("rst_pixel", int'({pix0[0], pix0[1], pix0[2]}), 0);
    @(negedge pixel_clk);
    rst = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge pixel_clk);
      #1;
      if (c >= 23) check($sformatf("ready_c%0d", c), int'(rdy0), int'(c == 25));
      else if (rdy0 !== 1'b0) check($sformatf("ready_c%0d", c), int'(rdy0), 0);
    end
    check("ready1_c25", int'(rdy1), 1);
    m_init();
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    fsync      = 1'b0;
    game_state = 2'b00;
    hpos       = 12'sd225;
    vpos       = 12'sd345;

    do_reset();

    probe(225, 345);
    check("star0_act", int'(act0), 1);
    check("star0_pix", int'({pix0[0], pix0[1], pix0[2]}), 'h606060);
    check("star0_twk_f0", int'({pix1[0], pix1[1], pix1[2]}), 'h303030);
    for (int j = 0; j < NS; j++) probe_model($sformatf("init_s%0d", j), m_x[j], m_y[j]);

    run_frame(2'b01);
    probe(225, 346);
    check("move_new_act", int'(act0), 1);
    probe(225, 345);
    check("move_old_act", int'(act0), 0);

    for (int i = 0; i < 5; i++) run_frame(2'b11);
    probe(225, 346);
    check("frozen_act", int'(act0), 1);
    check("frame_cnt_6", int'(dut0.frame_cnt), 6);
    check("twk_f6", int'({pix1[0], pix1[1], pix1[2]}), 'h303030);

    for (int i = 0; i < 2; i++) run_frame(2'b11);
    probe(225, 346);
    check("twk_f8", int'({pix1[0], pix1[1], pix1[2]}), 'h606060);
    probe(m_x[16], m_y[16]);
    check("layer2_twk", int'({pix1[0], pix1[1], pix1[2]}), 'hFFFFFF);
    check("layer2_pix", int'({pix0[0], pix0[1], pix0[2]}), 'hFFFFFF);

    probe(-1, 346);
    check("neg_h_act", int'(act0), 0);
    check("neg_h_pix", int'({pix0[0], pix0[1], pix0[2]}), 0);
    probe(225, 600);
    check("big_v_act", int'(act0), 0);
    check("big_v_pix", int'({pix0[0], pix0[1], pix0[2]}), 0);

    // A second fsync landing mid-UPDATE must be ignored entirely
    @(negedge pixel_clk);
    fsync      = 1'b1;
    game_state = 2'b01;
    @(negedge pixel_clk);
    fsync = 1'b0;
    repeat (5) @(negedge pixel_clk);
    fsync = 1'b1;
    @(negedge pixel_clk);
    fsync   = 1'b0;
    m_frame = m_frame + 1;
    m_update();
    repeat (30) @(negedge pixel_clk);
    check("frame_cnt_9", int'(dut0.frame_cnt), 9);
    for (int j = 0; j < NS; j++) probe_model($sformatf("f9_s%0d", j), m_x[j], m_y[j]);

    // Reset mid-UPDATE restarts the table from the seed
    @(negedge pixel_clk);
    fsync = 1'b1;
    @(negedge pixel_clk);
    fsync = 1'b0;
    repeat (5) @(negedge pixel_clk);
    do_reset();
    probe(225, 345);
    check("reseed_act", int'(act0), 1);
    check("frame_cnt_rst", int'(dut0.frame_cnt), 0);

    for (int i = 0; i < 134; i++) run_frame(2'b01);
    probe(225, 479);
    check("pre_wrap_act", int'(act0), 1);
    probe_model("pre_wrap", 225, 479);

    run_frame(2'b01);
    probe(225, 479);
    check("post_wrap_old", int'(act0), 0);
    probe(m_x[0], 0);
    check("post_wrap_new", int'(act0), 1);
    for (int j = 0; j < NS; j++) probe_model($sformatf("wrap_s%0d", j), m_x[j], m_y[j]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
